// File: rtl/hlsm_go_ctrl.sv
// hlsm_go_ctrl: push-button front end for the HLSM counter stage.
// Synchronizes and debounces a raw button, turns each accepted press into a
// single-cycle go pulse, waits for done, flags a timeout fault when done never
// arrives, and keeps a saturating count of completed runs.
module hlsm_go_ctrl #(
   parameter int unsigned DB_CYCLES      = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       btn,
   input  logic       done_in,
   output logic       go,
   output logic       busy,
   output logic       timeout,
   output logic [7:0] run_count
);

   // Terminal values for the 16-bit counters (full-width unsigned compare).
   localparam logic [15:0] DB_LAST = 16'(DB_CYCLES - 1);
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PULSE     = 2'd1,
      WAIT_DONE = 2'd2,
      FAULT     = 2'd3
   } state_t;

   state_t      state_reg;
   logic        s1_reg;
   logic        s2_reg;
   logic        db_reg;
   logic        db_d_reg;
   logic [15:0] dcnt_reg;
   logic [15:0] timer_reg;
   logic        press;

   // Rising edge of the debounced level; release edges never start anything.
   assign press = db_reg & ~db_d_reg;

   // Two-flop synchronizer, debounce filter and edge-detect delay.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         s1_reg   <= 1'b0;
         s2_reg   <= 1'b0;
         db_reg   <= 1'b0;
         db_d_reg <= 1'b0;
         dcnt_reg <= 16'd0;
      end else begin
         s1_reg   <= btn;
         s2_reg   <= s1_reg;
         db_d_reg <= db_reg;
         if (s2_reg == db_reg) begin
            dcnt_reg <= 16'd0;
         end else if (dcnt_reg == DB_LAST) begin
            db_reg   <= s2_reg;
            dcnt_reg <= 16'd0;
         end else begin
            dcnt_reg <= dcnt_reg + 16'd1;
         end
      end
   end

   // Control FSM with registered Moore outputs that follow the next state.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_reg <= IDLE;
         timer_reg <= 16'd0;
         go        <= 1'b0;
         busy      <= 1'b0;
         timeout   <= 1'b0;
         run_count <= 8'd0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (press) begin
                  state_reg <= PULSE;
                  go        <= 1'b1;
                  busy      <= 1'b1;
               end else begin
                  go        <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            PULSE: begin
               state_reg <= WAIT_DONE;
               timer_reg <= 16'd0;
               go        <= 1'b0;
               busy      <= 1'b1;
            end
            WAIT_DONE: begin
               timer_reg <= timer_reg + 16'd1;
               go        <= 1'b0;
               // done has priority over the limit when both land together
               if (done_in) begin
                  state_reg <= IDLE;
                  busy      <= 1'b0;
                  if (run_count != 8'hFF) begin
                     run_count <= run_count + 8'd1;
                  end
               end else if (timer_reg == TO_LAST) begin
                  state_reg <= FAULT;
                  busy      <= 1'b0;
                  timeout   <= 1'b1;
               end else begin
                  busy      <= 1'b1;
               end
            end
            FAULT: begin
               go   <= 1'b0;
               busy <= 1'b0;
               // a press here only acknowledges the fault, it never starts a run
               if (press) begin
                  state_reg <= IDLE;
                  timeout   <= 1'b0;
               end
            end
            default: begin
               state_reg <= IDLE;
               go        <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule
